// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: state encoding, default
// widths and the bit layout of the control word carried between stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 16;

  // Control word layout, LSB first: alu_src, alu_op[4:0], mem_to_reg,
  // mem_wrenable, reg_wrenable, jmp_type[3:0], halt.
  localparam int CTRL_ALU_SRC      = 0;
  localparam int CTRL_ALU_OP_LSB   = 1;
  localparam int CTRL_ALU_OP_W     = 5;
  localparam int CTRL_MEM_TO_REG   = 6;
  localparam int CTRL_MEM_WRENABLE = 7;
  localparam int CTRL_REG_WRENABLE = 8;
  localparam int CTRL_JMP_TYPE_LSB = 9;
  localparam int CTRL_JMP_TYPE_W   = 4;
  localparam int CTRL_HALT         = 13;

  function automatic logic [1:0] occupancy_of(input pipe_state_e st);
    case (st)
      PIPE_ONE:  return 2'd1;
      PIPE_FULL: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One {data, ctrl} holding register. Data is a plain enabled flop; ctrl is
// reset and can be cleared synchronously so a discarded entry reads as a bubble.
module pipe_entry_reg #(
  parameter int                 DATA_W   = 128,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  output logic [DATA_W-1:0] data_q,
  output logic [CTRL_W-1:0] ctrl_q
);

  // NOTE: the wide payload deliberately has no reset; only ctrl must be safe
  // after reset, and leaving data unreset keeps the reset tree off 128 flops.
  always_ff @(posedge clk) begin
    if (load_i) data_q <= data_d;
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ctrl_q <= CTRL_RST;
    else if (clear_i) ctrl_q <= CTRL_RST;
    else if (load_i)  ctrl_q <= ctrl_d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer and flush. in_ready is
// decoded from the state register only, so it never depends on out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = PIPE_DATA_W,
  parameter int                 CTRL_W   = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  pipe_state_e       state_q, state_d;
  logic              accept, send;
  logic              main_load, skid_load, main_from_skid;
  logic [DATA_W-1:0] main_data_d, main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_d, main_ctrl_q, skid_ctrl_q;

  assign in_ready  = (state_q != PIPE_FULL);
  assign out_valid = (state_q != PIPE_EMPTY);
  assign occupancy = occupancy_of(state_q);
  assign accept    = in_valid & in_ready;
  assign send      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PIPE_EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      PIPE_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = PIPE_ONE;
        end
      end
      PIPE_ONE: begin
        if (accept && send) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = PIPE_FULL;
        end else if (send) begin
          state_d   = PIPE_EMPTY;
        end
      end
      PIPE_FULL: begin
        if (send) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = PIPE_ONE;
        end
      end
      default: state_d = PIPE_EMPTY;
    endcase
    if (flush) state_d = PIPE_EMPTY;
  end

  assign main_data_d = main_from_skid ? skid_data_q : in_data;
  assign main_ctrl_d = main_from_skid ? skid_ctrl_q : in_ctrl;

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (main_load),
    .clear_i (flush),
    .data_d  (main_data_d),
    .ctrl_d  (main_ctrl_d),
    .data_q  (main_data_q),
    .ctrl_q  (main_ctrl_q)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (flush),
    .data_d  (in_data),
    .ctrl_d  (in_ctrl),
    .data_q  (skid_data_q),
    .ctrl_q  (skid_ctrl_q)
  );

  // Bubbles must never carry write-enables downstream, whatever main holds.
  assign out_data = main_data_q;
  assign out_ctrl = out_valid ? main_ctrl_q : CTRL_RST;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks of pipe_stage_skid against hand-computed
// values and a small queue model of the two held entries.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [15:0]  in_ctrl = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [15:0]  out_ctrl;
  logic [1:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] mq[$];
  logic [127:0] popped;
  int           n_acc  = 0;
  int           n_sent = 0;

  pipe_stage_skid dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = d[15:0];
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".occ"},   occupancy, 2'd0);
    check({tag, ".valid"}, out_valid, 1'b0);
    check({tag, ".ready"}, in_ready,  1'b1);
    check({tag, ".ctrl"},  out_ctrl,  16'h0);
  endtask

  // One clock of the reference model: two-entry FIFO, pop on send, push on accept.
  task automatic model_cycle();
    bit do_send, do_acc;
    @(posedge clk);
    do_send = (mq.size() > 0) && out_ready;
    do_acc  = in_valid && (mq.size() < 2);
    if (do_send) begin
      popped = mq.pop_front();
      n_sent++;
    end
    if (do_acc) begin
      mq.push_back(in_data);
      n_acc++;
    end
    #1;
    check("rnd.occ",   occupancy, mq.size());
    check("rnd.ready", in_ready,  mq.size() < 2);
    check("rnd.valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("rnd.data", out_data, mq[0]);
      check("rnd.ctrl", out_ctrl, mq[0][15:0]);
    end else begin
      check("rnd.ctrl", out_ctrl, 16'h0);
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [15:0]  cur;
    int unsigned  seq;

    // Power-on reset
    #2 rst_n = 1'b0;
    #2;
    check_idle("por");
    tick();
    rst_n = 1'b1;

    // Streaming 1..8 with out_ready high
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 128'(k));
      tick();
      check($sformatf("stream.data%0d", k), out_data, 128'(k));
      check($sformatf("stream.ready%0d", k), in_ready, 1'b1);
      check($sformatf("stream.occ%0d", k), occupancy, 2'd1);
    end
    drive(1'b0, '0);
    tick();
    check_idle("stream.end");

    // Backpressure: A, B captured, C held upstream, then released in order
    out_ready = 1'b0;
    drive(1'b1, 128'hA);
    tick();
    check("bp.a_data", out_data, 128'hA);
    check("bp.a_ready", in_ready, 1'b1);
    drive(1'b1, 128'hB);
    tick();
    check("bp.full_occ", occupancy, 2'd2);
    check("bp.full_ready", in_ready, 1'b0);
    check("bp.full_data", out_data, 128'hA);
    drive(1'b1, 128'hC);
    tick();
    tick();
    check("bp.hold_occ", occupancy, 2'd2);
    check("bp.hold_data", out_data, 128'hA);
    out_ready = 1'b1;
    tick();
    check("bp.b_data", out_data, 128'hB);
    check("bp.b_occ", occupancy, 2'd1);
    tick();
    check("bp.c_data", out_data, 128'hC);
    check("bp.c_occ", occupancy, 2'd1);
    drive(1'b0, '0);
    tick();
    check_idle("bp.end");

    // Flush while FULL with send pending and a new word offered
    out_ready = 1'b0;
    drive(1'b1, 128'h11);
    tick();
    drive(1'b1, 128'h22);
    tick();
    check("fl.full_occ", occupancy, 2'd2);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 128'h33);
    tick();
    flush = 1'b0;
    check_idle("fl.full");
    drive(1'b0, '0);
    tick();
    check_idle("fl.full_after");

    // Flush in ONE with a same-cycle accept and send
    drive(1'b1, 128'h44);
    tick();
    check("fl.one_data", out_data, 128'h44);
    drive(1'b1, 128'h55);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    check_idle("fl.one");
    tick();
    check_idle("fl.one_after");

    // Bubble safety: all-ones ctrl on the bus, never shown without valid
    in_valid = 1'b0;
    in_ctrl  = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bub.idle%0d", k), out_ctrl, 16'h0);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    check("bub.pass_ctrl", out_ctrl, 16'hFFFF);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bub.gated_ctrl", out_ctrl, 16'h0);
    check("bub.gated_valid", out_valid, 1'b0);

    // Reset mid-stream while FULL: outputs must react before any clock edge
    out_ready = 1'b0;
    drive(1'b1, 128'h66);
    tick();
    drive(1'b1, 128'h77);
    tick();
    check("rst.full_occ", occupancy, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst.mid");
    drive(1'b0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("rst.after");

    // Random valid/ready against the queue model; upstream holds until accepted
    seq = 32'h1000;
    mq.delete();
    drive(1'b0, '0);
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid || in_ready) begin
        seq++;
        d = {96'hC0DE, seq};
        drive(1'($urandom_range(0, 3) != 0), d);
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      model_cycle();
    end
    drive(1'b0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) model_cycle();
    check("rnd.count", 128'(n_sent), 128'(n_acc));
    check("rnd.final_occ", occupancy, 2'd0);
    cur = 16'(n_acc);
    check("rnd.some_traffic", cur > 16'd500, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
